pc_fetch_unit: RTL

- Consumer end of the next-address path: holds the PC, fetches instruction words from instruction memory, and presents them downstream with a valid/ready handshake.
- Sequential advance is PC+1 on a 30-bit word address. Branch and jump targets computed by the next-address logic arrive on the redirect input.
- Sits between the next-address datapath and decode.
- Contains one outstanding-request memory FSM and a 2-entry instruction buffer with flush on redirect.

---
 rtl/pc_fetch_unit_pkg.sv | 32 +++
 rtl/pc_fetch_unit_fetch_buffer.sv | 142 ++++++++++++++
 rtl/pc_fetch_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_pkg
// Description : Shared types and defaults for the PC / instruction-fetch
//               slice: fetch FSM encoding, default widths, reset PC and the
//               instruction-buffer entry layout.
// Contents    : c_ADDR_W, c_DATA_W, c_RESET_PC, fetch_state_e, fetch_entry_t
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_unit_pkg;

  // Word-address width (byte address is {pc, 2'b00}) and instruction width.
  localparam int c_ADDR_W = 30;
  localparam int c_DATA_W = 32;

  // Word address fetched first after reset.
  localparam logic [c_ADDR_W-1:0] c_RESET_PC = 30'h0;

  // Memory-side fetch FSM: either free to issue, or one response outstanding.
  typedef enum logic [0:0] {
    FETCH_ISSUE = 1'b0,
    FETCH_WAIT  = 1'b1
  } fetch_state_e;

  // One instruction-buffer entry: the word address and the fetched word.
  typedef struct packed {
    logic [c_ADDR_W-1:0] pc;
    logic [c_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_fetch_buffer
// Description : Two-entry instruction FIFO with synchronous flush. The head
//               entry lives in dedicated registers so the instruction, its
//               PC and PC+1 leave the block straight from flops.
// Ports       : clk, reset          - clock, async active-high reset
//               flush               - drop every entry (wins over push/pop)
//               push, push_pc/instr - write a new entry at the tail
//               pop                 - retire the head (ignored when empty)
//               head_valid/pc/instr - current head entry
//               head_pc_plus1       - head_pc + 1, wrapping
//               full, empty         - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit_fetch_buffer
  import pc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_instr,
  input  logic              pop,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_instr,
  output logic [ADDR_W-1:0] head_pc_plus1,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W-1:0] c_PC_ONE = ADDR_W'(1);

  logic [1:0]        r_count;
  logic [1:0]        w_count_next;
  logic [ADDR_W-1:0] r_head_pc;
  logic [ADDR_W-1:0] r_head_pc1;
  logic [DATA_W-1:0] r_head_instr;
  logic [ADDR_W-1:0] r_tail_pc;
  logic [DATA_W-1:0] r_tail_instr;
  logic [ADDR_W-1:0] w_head_pc_next;
  logic [DATA_W-1:0] w_head_instr_next;
  logic              w_pop;
  logic              w_load_head;
  logic              w_head_from_tail;
  logic              w_load_tail;

  assign w_pop = pop && (r_count != 2'd0);

  // Entry movement. Entry 0 is always the head; entry 1 only ever holds the
  // second-oldest word, so a pop at occupancy 2 shifts tail into head.
  always_comb begin
    w_load_head      = 1'b0;
    w_head_from_tail = 1'b0;
    w_load_tail      = 1'b0;
    w_count_next     = r_count;
    if (flush) begin
      w_count_next = 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (push) begin
            w_load_head  = 1'b1;
            w_count_next = 2'd1;
          end
        end
        2'd1: begin
          if (push && w_pop) begin
            // Head retires and the new word becomes the head directly.
            w_load_head = 1'b1;
          end else if (push) begin
            w_load_tail  = 1'b1;
            w_count_next = 2'd2;
          end else if (w_pop) begin
            w_count_next = 2'd0;
          end
        end
        2'd2: begin
          // A push without a pop cannot happen here: the fetch side stops
          // requesting once occupancy plus outstanding reaches two.
          if (w_pop) begin
            w_head_from_tail = 1'b1;
            if (push) begin
              w_load_tail = 1'b1;
            end else begin
              w_count_next = 2'd1;
            end
          end
        end
        default: begin
          w_count_next = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_head_pc_next    = push_pc;
    w_head_instr_next = push_instr;
    if (w_head_from_tail) begin
      w_head_pc_next    = r_tail_pc;
      w_head_instr_next = r_tail_instr;
    end
  end

  // Head data is not cleared on flush; head_valid alone qualifies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= 2'd0;
      r_head_pc    <= '0;
      r_head_pc1   <= c_PC_ONE;
      r_head_instr <= '0;
      r_tail_pc    <= '0;
      r_tail_instr <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_load_head || w_head_from_tail) begin
        r_head_pc    <= w_head_pc_next;
        r_head_pc1   <= w_head_pc_next + c_PC_ONE;
        r_head_instr <= w_head_instr_next;
      end
      if (w_load_tail) begin
        r_tail_pc    <= push_pc;
        r_tail_instr <= push_instr;
      end
    end
  end

  assign head_valid    = (r_count != 2'd0);
  assign head_pc       = r_head_pc;
  assign head_instr    = r_head_instr;
  assign head_pc_plus1 = r_head_pc1;
  assign full          = (r_count == 2'd2);
  assign empty         = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Holds the program counter, fetches instruction words from
//               instruction memory with at most one request outstanding,
//               and hands them to decode through a 2-entry buffer with a
//               valid/ready handshake. Redirects flush the buffer and kill
//               any in-flight response.
// Ports       : clk, reset                   - clock, async active-high reset
//               redirect_valid/addr          - branch/jump target pulse
//               imem_req/addr, imem_gnt      - request channel
//               imem_rvalid, imem_rdata      - in-order response channel
//               instr_valid/instr/instr_pc   - buffer head to decode
//               instr_ready                  - decode accepts the head
//               pc_plus1                     - instr_pc + 1, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = c_ADDR_W,
  parameter int                DATA_W   = c_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_plus1
);

  localparam logic [0:0]        c_ST_ISSUE = FETCH_ISSUE;
  localparam logic [0:0]        c_ST_WAIT  = FETCH_WAIT;
  localparam logic [ADDR_W-1:0] c_PC_ONE   = ADDR_W'(1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;   // address of the request currently in flight
  logic              r_kill;     // the in-flight response is stale
  logic              r_req_en;   // holds imem_req low until the first edge after reset

  logic              w_outstanding;
  logic [1:0]        w_occupancy;
  logic              w_grant;
  logic              w_rsp;
  logic              w_push;
  logic              w_pop;
  logic              w_buf_full;
  logic              w_buf_empty;

  assign w_outstanding = (r_state == c_ST_WAIT);
  assign w_occupancy   = w_buf_full ? 2'd2 : (w_buf_empty ? 2'd0 : 2'd1);

  // A request is only raised when its response is guaranteed a buffer slot,
  // which is what keeps the buffer from ever overflowing.
  assign imem_req  = r_req_en && (r_state == c_ST_ISSUE) &&
                     (({1'b0, w_occupancy} + {2'b00, w_outstanding}) < 3'd2);
  assign imem_addr = r_pc;

  assign w_grant = imem_req && imem_gnt;
  // Responses are only meaningful while waiting; a stray rvalid in ISSUE
  // (e.g. a late response to a request made before reset) is ignored.
  assign w_rsp   = w_outstanding && imem_rvalid;
  // A response landing in the redirect cycle belongs to the old stream.
  assign w_push  = w_rsp && !r_kill && !redirect_valid;
  assign w_pop   = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= c_ST_ISSUE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_kill   <= 1'b0;
      r_req_en <= 1'b0;
    end else begin
      r_req_en <= 1'b1;

      case (r_state)
        c_ST_ISSUE: begin
          if (w_grant) begin
            r_state  <= c_ST_WAIT;
            r_req_pc <= r_pc;
          end
        end
        c_ST_WAIT: begin
          if (imem_rvalid) begin
            r_state <= c_ST_ISSUE;
          end
        end
        default: begin
          r_state <= c_ST_ISSUE;
        end
      endcase

      // Redirect overrides the sequential advance, including on a grant
      // cycle: the granted fetch is then stale and the new stream restarts
      // at the target itself.
      if (redirect_valid) begin
        r_pc <= redirect_addr;
      end else if (w_grant) begin
        r_pc <= r_pc + c_PC_ONE;
      end

      // Only one response can ever be in flight, so a single kill bit is
      // enough no matter how many redirects arrive before it returns.
      if (w_rsp) begin
        r_kill <= 1'b0;
      end else if (redirect_valid && (w_outstanding || w_grant)) begin
        r_kill <= 1'b1;
      end
    end
  end

  pc_fetch_unit_fetch_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fetch_buffer (
    .clk           (clk),
    .reset         (reset),
    .flush         (redirect_valid),
    .push          (w_push),
    .push_pc       (r_req_pc),
    .push_instr    (imem_rdata),
    .pop           (w_pop),
    .head_valid    (instr_valid),
    .head_pc       (instr_pc),
    .head_instr    (instr),
    .head_pc_plus1 (pc_plus1),
    .full          (w_buf_full),
    .empty         (w_buf_empty)
  );

endmodule
`default_nettype wire
